uart_word_tx: RTL and testbench



---
 rtl/uart_word_tx.sv | 204 ++++++++++++++++++++
 tb/tb_uart_word_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// Purpose: UART 8N1 transmitter fed by a small queue of 32-bit words or single bytes.
// Latency: a write sampled at edge N into an idle, empty block drives tx low at edge N+2.
// Backpressure: full is asserted at FIFO_DEPTH entries; a write while full is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk        CPU clock
//   rst        synchronous reset, active-high; aborts any frame and discards queued data
//   wr_en      enqueue request
//   wr_data    32-bit payload
//   word_mode  1 = send all 4 bytes of wr_data, LSB byte first; 0 = send wr_data[7:0]
//   full       queue holds FIFO_DEPTH entries
//   busy       queue non-empty or a frame is still on the line
//   overflow   sticky flag for a dropped write
//   tx         serial line, idles high
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        word_mode,
    output logic        full,
    output logic        busy,
    output logic        overflow,
    output logic        tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Entry queue: {word_mode, wr_data}
    // ------------------------------------------------------------------
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic          push;
    logic          pop;
    logic [32:0]   head;

    // full comes from the registered count, so a write while full is dropped
    // even when the FSM pops in that same cycle.
    assign full = (count == DEPTH_N);
    assign push = wr_en && !full;
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {word_mode, wr_data};
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_n;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_n;
    logic [1:0]    bytes_left;
    logic [1:0]    bytes_n;
    logic [31:0]   shift;
    logic [31:0]   shift_n;
    logic          tx_n;
    logic          baud_done;
    logic          line_active;

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            bytes_left  <= '0;
            shift       <= '0;
            tx          <= 1'b1;
            line_active <= 1'b0;
        end else begin
            state       <= state_n;
            baud_cnt    <= baud_n;
            bit_idx     <= bit_n;
            bytes_left  <= bytes_n;
            shift       <= shift_n;
            tx          <= tx_n;
            line_active <= (state != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        bytes_n = bytes_left;
        shift_n = shift;
        pop     = 1'b0;
        tx_n    = 1'b1;

        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                baud_n = '0;
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_n = head[31:0];
                    bytes_n = head[32] ? 2'd3 : 2'd0;
                    state_n = START;
                end
            end

            START: begin
                tx_n = 1'b0;
                if (baud_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                tx_n = shift[bit_idx];
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            STOP: begin
                tx_n = 1'b1;
                if (baud_done) begin
                    baud_n = '0;
                    // Remaining bytes of a word follow with no idle gap.
                    if (bytes_left != 2'd0) begin
                        shift_n = shift >> 8;
                        bytes_n = bytes_left - 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // tx is registered one cycle behind the state, so line_active keeps busy
    // high until the stop bit has actually finished on the pin.
    assign busy = (state != IDLE) || (count != '0) || line_active;

endmodule

// File: tb/tb_uart_word_tx.sv
// Purpose: directed self-checking bench for uart_word_tx with CLKS_PER_BIT=4, FIFO_DEPTH=2.
// Latency: checks start-bit latency, per-bit timing at bit centres, word contiguity and inter-entry gap.
// Backpressure: exercises full/overflow, reset abort and pointer wrap.
module tb_uart_word_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        word_mode;
    logic        full;
    logic        busy;
    logic        overflow;
    logic        tx;

    int checks = 0;
    int errors = 0;

    uart_word_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .word_mode(word_mode),
        .full     (full),
        .busy     (busy),
        .overflow (overflow),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] data, input logic mode);
        wr_en     = 1'b1;
        wr_data   = data;
        word_mode = mode;
        tick();
        wr_en     = 1'b0;
    endtask

    // Ticks until tx is low; n is the number of edges taken, max_cyc+1 on timeout.
    task automatic wait_fall(input int max_cyc, output int n);
        n = 0;
        while (tx !== 1'b0 && n <= max_cyc) begin
            tick();
            n++;
        end
    endtask

    // Called 'pre' edges after the falling edge of the start bit; samples each bit
    // at its centre and returns 38 edges after the fall (middle of the stop bit).
    task automatic check_frame(input logic [7:0] b, input int pre, input string tag);
        repeat (2 - pre) tick();
        chk($sformatf("%s_start", tag), tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) tick();
            chk($sformatf("%s_d%0d", tag, i), tx, b[i]);
        end
        repeat (CPB) tick();
        chk($sformatf("%s_stop", tag), tx, 1'b1);
    endtask

    logic [31:0] word_val;
    logic [7:0]  byte_val;
    int          n;

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        word_mode = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        rst = 1'b0;
        tick();

        // Single byte 0xA5
        do_write(32'h0000_00A5, 1'b0);
        chk("byte_busy_after_push", busy, 1'b1);
        wait_fall(10, n);
        chk("byte_latency", n, 2);
        check_frame(8'hA5, 0, "byte");
        tick();
        chk("byte_busy_f39", busy, 1'b1);
        tick();
        chk("byte_busy_f40", busy, 1'b0);
        chk("byte_tx_idle", tx, 1'b1);

        // Word 0x12345678: four contiguous frames, LSB byte first
        word_val = 32'h1234_5678;
        do_write(word_val, 1'b1);
        wait_fall(10, n);
        chk("word_latency", n, 2);
        for (int i = 0; i < 4; i++) begin
            byte_val = word_val[8*i +: 8];
            check_frame(byte_val, 0, $sformatf("word_b%0d", i));
            if (i < 3) begin
                repeat (2) tick();
                chk($sformatf("word_contig_%0d", i), tx, 1'b0);
            end else begin
                tick();
                chk("word_busy_f159", busy, 1'b1);
                tick();
                chk("word_busy_f160", busy, 1'b0);
            end
        end

        // Fill and overflow: 3 back-to-back writes, then a dropped 4th
        do_write(32'h0000_0011, 1'b0);
        do_write(32'h0000_0022, 1'b0);
        do_write(32'h0000_0033, 1'b0);
        chk("fill_full", full, 1'b1);
        chk("fill_ovf_clear", overflow, 1'b0);
        do_write(32'h0000_0044, 1'b0);
        chk("fill_ovf_set", overflow, 1'b1);
        chk("fill_still_full", full, 1'b1);
        check_frame(8'h11, 1, "fill1");
        wait_fall(10, n);
        chk("fill_gap1", n, 3);
        check_frame(8'h22, 0, "fill2");
        wait_fall(10, n);
        chk("fill_gap2", n, 3);
        check_frame(8'h33, 0, "fill3");
        wait_fall(60, n);
        chk("fill_no_4th", (n > 60), 1'b1);
        chk("fill_idle_busy", busy, 1'b0);
        chk("fill_ovf_sticky", overflow, 1'b1);

        // Reset mid-frame with one entry still queued
        do_write(32'h0000_00A5, 1'b0);
        do_write(32'h0000_00C3, 1'b0);
        wait_fall(10, n);
        chk("abort_latency", n, 1);
        repeat (16) tick();
        chk("abort_bit3", tx, 1'b0);
        chk("abort_pre_full", full, 1'b0);
        chk("abort_pre_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_full", full, 1'b0);
        chk("abort_ovf", overflow, 1'b0);
        rst = 1'b0;
        wait_fall(60, n);
        chk("abort_no_restart", (n > 60), 1'b1);
        chk("abort_idle_busy", busy, 1'b0);

        // Pointer wrap: five single bytes, each after the previous completes
        for (int k = 1; k <= 5; k++) begin
            do_write(32'(k), 1'b0);
            wait_fall(10, n);
            chk($sformatf("wrap%0d_latency", k), n, 2);
            check_frame(8'(k), 0, $sformatf("wrap%0d", k));
            repeat (2) tick();
            chk($sformatf("wrap%0d_busy", k), busy, 1'b0);
        end
        chk("wrap_ovf", overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
